// File: rtl/sha256_block_engine.sv
// Register-mapped SHA-256 compression engine: all 64 rounds of one block, ROUNDS_PER_CYCLE rounds per clock.
// Optional completion interrupt port IRQ when SHA256_IRQ_EN is defined.
module sha256_block_engine #(
  parameter logic [3:0] BASE_ADDR        = 4'h4,
  parameter int         ROUNDS_PER_CYCLE = 1
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic [15:0] WRADDR,
  input  logic [3:0]  BYTEEN,
  input  logic        WREN,
  input  logic [31:0] WDATA,
  input  logic [15:0] RDADDR,
  input  logic        RDEN,
  output logic [31:0] RDATA
`ifdef SHA256_IRQ_EN
  ,
  output logic        IRQ
`endif
);

  // state | meaning
  // IDLE  | waiting for START; HIN/M writable
  // RUN   | evaluating ROUNDS_PER_CYCLE rounds per clock
  // FINAL | feed-forward add into HOUT, raise DONE
  typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rpc
    $error("sha256_block_engine: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [6:0] RPC7     = 7'(ROUNDS_PER_CYCLE);
  localparam logic [6:0] LAST_CNT = 7'(64 - ROUNDS_PER_CYCLE);

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  state_t      state, state_nxt;
  logic [6:0]  cnt;
  logic        busy, done;
  logic [31:0] hin [8];
  logic [31:0] hin_eff [8];
  logic [31:0] hout [8];
  logic [31:0] msg [16];
  logic [31:0] wv [8];
  logic [31:0] wv_nxt [8];
  logic [31:0] sched [16];
  logic [31:0] sched_nxt [16];
  logic [31:0] t1, t2, w_new, rd_val;
  logic [6:0]  rnd;

  logic [9:0]  woff, roff;
  logic        wr_hit, rd_hit, ctrl_wr, start_req, loadiv_req, status_wr;
  logic        unused_bits;

  assign woff       = WRADDR[11:2];
  assign roff       = RDADDR[11:2];
  assign wr_hit     = WREN && (WRADDR[15:12] == BASE_ADDR);
  assign rd_hit     = RDEN && (RDADDR[15:12] == BASE_ADDR);
  assign ctrl_wr    = wr_hit && (woff == 10'h020) && BYTEEN[0];
  assign start_req  = ctrl_wr && WDATA[0];
  assign loadiv_req = ctrl_wr && WDATA[1];
  assign status_wr  = wr_hit && (woff == 10'h021);
  assign unused_bits = ^{WRADDR[1:0], RDADDR[1:0], rnd[6]};

  // HIN as it will be after this cycle's write; START samples this so LOADIV+START takes the IV.
  always_comb begin
    hin_eff = hin;
    if (!busy) begin
      if (loadiv_req) hin_eff = IV;
      else if (wr_hit && woff[9:3] == 7'd0) hin_eff[woff[2:0]] = merge(hin[woff[2:0]], WDATA, BYTEEN);
    end
  end

  always_comb begin
    wv_nxt    = wv;
    sched_nxt = sched;
    t1        = '0;
    t2        = '0;
    w_new     = '0;
    rnd       = '0;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      rnd   = cnt + 7'(j);
      t1    = wv_nxt[7] + big_s1(wv_nxt[4]) + ((wv_nxt[4] & wv_nxt[5]) ^ (~wv_nxt[4] & wv_nxt[6]))
              + K[rnd[5:0]] + sched_nxt[0];
      t2    = big_s0(wv_nxt[0]) + ((wv_nxt[0] & wv_nxt[1]) ^ (wv_nxt[0] & wv_nxt[2]) ^ (wv_nxt[1] & wv_nxt[2]));
      w_new = small_s1(sched_nxt[14]) + sched_nxt[9] + small_s0(sched_nxt[1]) + sched_nxt[0];
      wv_nxt[7] = wv_nxt[6];
      wv_nxt[6] = wv_nxt[5];
      wv_nxt[5] = wv_nxt[4];
      wv_nxt[4] = wv_nxt[3] + t1;
      wv_nxt[3] = wv_nxt[2];
      wv_nxt[2] = wv_nxt[1];
      wv_nxt[1] = wv_nxt[0];
      wv_nxt[0] = t1 + t2;
      for (int i = 0; i < 15; i++) sched_nxt[i] = sched_nxt[i+1];
      sched_nxt[15] = w_new;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_req) state_nxt = RUN;
      RUN:     if (cnt == LAST_CNT) state_nxt = FINAL;
      FINAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    rd_val = '0;
    if (roff < 10'h008)      rd_val = hin[roff[2:0]];
    else if (roff < 10'h010) rd_val = hout[roff[2:0]];
    else if (roff < 10'h020) rd_val = msg[roff[3:0]];
    else if (roff == 10'h021) rd_val = {30'd0, done, busy};
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      for (int i = 0; i < 8; i++) begin
        hin[i]  <= '0;
        hout[i] <= '0;
        wv[i]   <= '0;
      end
      for (int i = 0; i < 16; i++) begin
        msg[i]   <= '0;
        sched[i] <= '0;
      end
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      RDATA <= '0;
`ifdef SHA256_IRQ_EN
      IRQ   <= 1'b0;
`endif
    end else begin
      hin <= hin_eff;
      if (!busy && wr_hit && woff[9:4] == 6'h01) msg[woff[3:0]] <= merge(msg[woff[3:0]], WDATA, BYTEEN);
      if (status_wr) begin
        done <= 1'b0;
`ifdef SHA256_IRQ_EN
        IRQ  <= 1'b0;
`endif
      end
      case (state)
        IDLE: if (start_req) begin
          wv    <= hin_eff;
          sched <= msg;
          busy  <= 1'b1;
          done  <= 1'b0;
          cnt   <= '0;
        end
        RUN: begin
          wv    <= wv_nxt;
          sched <= sched_nxt;
          cnt   <= cnt + RPC7;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) hout[i] <= hin[i] + wv[i];
          busy <= 1'b0;
          done <= 1'b1;
`ifdef SHA256_IRQ_EN
          IRQ  <= 1'b1;
`endif
        end
        default: ;
      endcase
      if (rd_hit) RDATA <= rd_val;
    end
  end

endmodule
